fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the combinational 32-word instruction memory for the instruction-fetch stage. Owns the program counter, drives the word address into the memory each cycle, captures the returned instruction word with its PC into a small queue, and hands instructions to decode over a valid/ready handshake. Accepts branch/jump redirects that flush the queue, and traps fetches outside the populated memory range.

## Interface

- RESET_PC, 32'h0000_0000: byte PC loaded on reset; must be 4-byte aligned.
- MEM_WORDS, 32: number of valid instruction-memory words; word index ≥ MEM_WORDS is out of range.
- QUEUE_DEPTH, 2: instruction queue entries; power of two, 2..8.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  word index to instruction memory: {2'b00, pc[31:2]}.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc, flush queue.
- redirect_pc  in  32  byte target PC for redirect.
- dec_valid  out  1  queue head holds a valid instruction.
- dec_instr  out  32  instruction at queue head.
- dec_pc  out  32  byte PC of dec_instr.
- dec_ready  in  1  decode accepts head this cycle.
- fetch_fault  out  1  fetch stopped: out-of-range or misaligned PC.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current number of queued entries.

## Operation

- States: RUN, FAULT.
- PC is a byte address; each successful fetch increments it by 4, 32-bit wrap (32'hFFFF_FFFC + 4 → 0, which then faults if out of range only by index rule).
- RUN, per cycle, in priority order:
  - redirect_valid: queue flushed (count → 0), pc ← redirect_pc, no enqueue, no dequeue counted. If redirect_pc[1:0] ≠ 0 → FAULT.
  - pc[31:2] ≥ MEM_WORDS: no enqueue, → FAULT; queued entries continue to drain.
  - else enqueue {pc, imem_data} if count < QUEUE_DEPTH, or count == QUEUE_DEPTH and dequeue this cycle; on enqueue pc ← pc + 4. Otherwise pc holds (stall).
- Dequeue when dec_valid && dec_ready; head advances.
- FAULT: no enqueue, pc holds, fetch_fault = 1. Only a redirect with aligned, in-range target returns to RUN (flushes queue, pc ← target); a misaligned or out-of-range redirect stays in FAULT with pc ← target. Reset also exits.
- Queue is a circular buffer; read/write pointers wrap modulo QUEUE_DEPTH; count never exceeds QUEUE_DEPTH nor goes negative.

## Timing

- Reset values: pc = RESET_PC, state RUN, queue empty, dec_valid 0, dec_instr 0, dec_pc 0, fetch_fault 0, queue_count 0; imem_addr = {2'b00, RESET_PC[31:2]}.
- imem_addr is a direct function of the pc register (valid same cycle pc updates); imem_data sampled at the same edge.
- Fetch latency: instruction at pc enqueued at edge N; dec_valid high after edge N (cycle N+1). First dec_valid after reset release: 1 cycle.
- Redirect sampled at edge N: dec_valid low in cycle N+1; target enqueued at edge N+1; dec_valid high in cycle N+2 with dec_pc = target.
- Redirect and dec_ready same cycle: flush wins; the dequeue is discarded.
- Full queue with dec_ready high: push and pop in the same cycle; count unchanged, throughput 1 instr/cycle.
- While dec_valid && !dec_ready, dec_instr/dec_pc hold stable.
- fetch_fault asserts the cycle after the edge entering FAULT; deasserts the cycle after the exiting redirect.
- Reset asserted mid-operation: all state returns to reset values at that edge, regardless of redirect_valid.

## Test plan

- Reset, memory preloaded word i = 32'hA000_0000+i, dec_ready=1 → dec_valid from cycle 1, dec_pc 0,4,8,… dec_instr A000_0000, A000_0001,… one per cycle.
- dec_ready=0 for 5 cycles, QUEUE_DEPTH=2 → queue_count saturates at 2, pc holds at 8, dec_pc stays 0; release → 0,4,8 in order, no gaps or duplicates.
- Redirect to 32'h40 while queue full → next cycle dec_valid=0, queue_count=0; following cycle dec_pc=0x40, dec_instr=word 16.
- Sequential fetch reaching pc=0x80 (word 32, MEM_WORDS=32) → word 31 delivered, then fetch_fault=1, no further dec_valid; redirect to 0x10 → fault clears, dec_pc=0x10 two cycles later.
- Redirect to 0x06 (misaligned) → FAULT, fetch_fault=1, queue empty; assert reset mid-fault → all outputs at reset values, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads the 32-word imem,
// queues {pc, instr} for decode, handles redirects and fetch faults.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   imem_addr/data  word index out, instruction word back (combinational)
//   redirect_*      one-cycle redirect pulse with byte target PC
//   dec_*           valid/ready handshake carrying head instr and its PC
//   fetch_fault     fetch stopped on out-of-range or misaligned PC
//   queue_count     number of queued entries
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_WORDS   = 32,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_data,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         dec_valid,
  output logic [31:0]                  dec_instr,
  output logic [31:0]                  dec_pc,
  input  logic                         dec_ready,
  output logic                         fetch_fault,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          enq, deq, flush;

  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [31:0]   q_instr [QUEUE_DEPTH];

  function automatic logic in_range(input logic [29:0] widx);
    return {2'b00, widx} < 32'(MEM_WORDS);
  endfunction

  assign imem_addr   = {2'b00, pc[31:2]};
  assign dec_valid   = (count != '0);
  assign dec_instr   = dec_valid ? q_instr[rd_ptr] : '0;
  assign dec_pc      = dec_valid ? q_pc[rd_ptr] : '0;
  assign fetch_fault = (state == FAULT);
  assign queue_count = count;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    enq       = 1'b0;
    flush     = 1'b0;
    deq       = dec_valid && dec_ready;
    unique case (state)
      RUN: begin
        if (redirect_valid) begin
          // flush drops any same-cycle dequeue
          flush  = 1'b1;
          deq    = 1'b0;
          pc_nxt = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) state_nxt = FAULT;
        end else if (!in_range(pc[31:2])) begin
          state_nxt = FAULT;
        end else if (count < DEPTH || deq) begin
          enq    = 1'b1;
          pc_nxt = pc + 32'd4;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          flush  = 1'b1;
          deq    = 1'b0;
          pc_nxt = redirect_pc;
          if (redirect_pc[1:0] == 2'b00 && in_range(redirect_pc[31:2]))
            state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        // power-of-two depth: pointers wrap naturally
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq && !deq) count <= count + 1'b1;
        else if (!enq && deq) count <= count - 1'b1;
      end
    end
  end

  // payload storage needs no reset; outputs are gated by dec_valid
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus
// a full-memory streaming sequence ending in a fetch fault.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        fetch_fault;
  logic [1:0]  queue_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory: word i holds A000_0000 + i
  always_comb begin
    if (imem_addr < 32'd32) imem_data = 32'hA000_0000 + imem_addr;
    else imem_data = 32'hFFFF_FFFF;
  end

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .MEM_WORDS  (32),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready),
    .fetch_fault   (fetch_fault),
    .queue_count   (queue_count)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [1:0]  ecnt;
    logic        ef;
    logic [31:0] eaddr;
  } vec_t;

  localparam int NV = 22;
  localparam logic [31:0] A0 = 32'hA000_0000;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    logic        prev_rst;
    logic [31:0] exp_pc;

    //         rst rv  rpc    rdy  ev  epc    ein       cnt ef  addr
    tbl[0]  = '{0, 0, 32'h0,  0,   0, 32'h0,  32'h0,    0, 0, 32'h0};
    tbl[1]  = '{0, 0, 32'h0,  0,   1, 32'h0,  A0,       1, 0, 32'h1};
    tbl[2]  = '{0, 0, 32'h0,  0,   1, 32'h0,  A0,       2, 0, 32'h2};
    tbl[3]  = '{0, 0, 32'h0,  0,   1, 32'h0,  A0,       2, 0, 32'h2};
    tbl[4]  = '{0, 0, 32'h0,  0,   1, 32'h0,  A0,       2, 0, 32'h2};
    tbl[5]  = '{0, 0, 32'h0,  1,   1, 32'h0,  A0,       2, 0, 32'h2};
    tbl[6]  = '{0, 0, 32'h0,  1,   1, 32'h4,  A0+1,     2, 0, 32'h3};
    tbl[7]  = '{0, 1, 32'h40, 1,   1, 32'h8,  A0+2,     2, 0, 32'h4};
    tbl[8]  = '{0, 0, 32'h0,  1,   0, 32'h0,  32'h0,    0, 0, 32'h10};
    tbl[9]  = '{0, 0, 32'h0,  1,   1, 32'h40, A0+'h10,  1, 0, 32'h11};
    tbl[10] = '{0, 1, 32'h7C, 1,   1, 32'h44, A0+'h11,  1, 0, 32'h12};
    tbl[11] = '{0, 0, 32'h0,  1,   0, 32'h0,  32'h0,    0, 0, 32'h1F};
    tbl[12] = '{0, 0, 32'h0,  1,   1, 32'h7C, A0+'h1F,  1, 0, 32'h20};
    tbl[13] = '{0, 0, 32'h0,  1,   0, 32'h0,  32'h0,    0, 1, 32'h20};
    tbl[14] = '{0, 1, 32'h10, 1,   0, 32'h0,  32'h0,    0, 1, 32'h20};
    tbl[15] = '{0, 0, 32'h0,  1,   0, 32'h0,  32'h0,    0, 0, 32'h4};
    tbl[16] = '{0, 1, 32'h6,  1,   1, 32'h10, A0+4,     1, 0, 32'h5};
    tbl[17] = '{0, 1, 32'h100,1,   0, 32'h0,  32'h0,    0, 1, 32'h1};
    tbl[18] = '{1, 1, 32'h20, 1,   0, 32'h0,  32'h0,    0, 1, 32'h40};
    tbl[19] = '{0, 0, 32'h0,  1,   0, 32'h0,  32'h0,    0, 0, 32'h0};
    tbl[20] = '{0, 0, 32'h0,  1,   1, 32'h0,  A0,       1, 0, 32'h1};
    tbl[21] = '{0, 0, 32'h0,  1,   1, 32'h4,  A0+1,     1, 0, 32'h2};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // each row: check outputs of this cycle, then drive its inputs
    prev_rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      chk("dec_valid", i, 32'(dec_valid), 32'(tbl[i].ev));
      chk("queue_count", i, 32'(queue_count), 32'(tbl[i].ecnt));
      chk("fetch_fault", i, 32'(fetch_fault), 32'(tbl[i].ef));
      chk("imem_addr", i, imem_addr, tbl[i].eaddr);
      if (tbl[i].ev || prev_rst) begin
        chk("dec_pc", i, dec_pc, tbl[i].epc);
        chk("dec_instr", i, dec_instr, tbl[i].ein);
      end
      reset          = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      dec_ready      = tbl[i].rdy;
      prev_rst       = tbl[i].rst;
      @(negedge clk);
    end

    // stream the whole memory, then expect a fault at word 32
    reset          = 1'b1;
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    exp_pc = 32'h0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (dec_valid) begin
        chk("stream_pc", c, dec_pc, exp_pc);
        chk("stream_instr", c, dec_instr, A0 + (exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
      end
      if (fetch_fault) break;
    end
    chk("stream_words", 0, exp_pc, 32'h80);
    chk("stream_fault", 0, 32'(fetch_fault), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fault_no_valid", c, 32'(dec_valid), 32'd0);
      chk("fault_addr", c, imem_addr, 32'h20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
